// File: rtl/fu_load_nb.sv
// Non-blocking multi-entry load unit: issue -> SQ forward lookup -> cache read / refill wait -> complete.
// Latency from issue cycle N: full forward N+2, cache hit N+3, misaligned N+1. Refill is unbounded.
// Backpressure: fu_ready drops when no FREE entry. complete_stall holds the presented result stable.
// Ports: clock/reset, issue_* in, fu_ready out, squash in, sq_lookup_* out / sq_* in,
//        cache_req/cache_addr out / cache_hit/cache_data in, broadcast_* in, complete_* out.
module fu_load_nb #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int PRW   = 6,
  parameter int ROBW  = 5,
  parameter int SQW   = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [XLEN-1:0] issue_base,
  input  logic [XLEN-1:0] issue_imm,
  input  logic [2:0]      issue_funct,
  input  logic [PRW-1:0]  issue_dest_pr,
  input  logic [ROBW-1:0] issue_rob,
  input  logic [SQW-1:0]  issue_sq_tail,
  output logic            fu_ready,
  input  logic            squash,
  output logic            sq_lookup_valid,
  output logic [XLEN-1:0] sq_lookup_addr,
  output logic [SQW-1:0]  sq_lookup_tail,
  input  logic            sq_stall,
  input  logic [3:0]      sq_usebytes,
  input  logic [XLEN-1:0] sq_data,
  output logic            cache_req,
  output logic [XLEN-1:0] cache_addr,
  input  logic            cache_hit,
  input  logic [XLEN-1:0] cache_data,
  input  logic            broadcast_en,
  input  logic [XLEN-1:0] broadcast_addr,
  input  logic [XLEN-1:0] broadcast_data,
  input  logic            complete_stall,
  output logic            complete_valid,
  output logic [PRW-1:0]  complete_dest_pr,
  output logic [ROBW-1:0] complete_rob,
  output logic [XLEN-1:0] complete_value,
  output logic            complete_exc
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_FREE, S_SQ, S_CACHE, S_MISS, S_DONE} state_t;

  state_t          st_q   [DEPTH], st_d   [DEPTH];
  logic [XLEN-1:0] addr_q [DEPTH], addr_d [DEPTH];
  logic [2:0]      fn_q   [DEPTH], fn_d   [DEPTH];
  logic [PRW-1:0]  tag_q  [DEPTH], tag_d  [DEPTH];
  logic [ROBW-1:0] rob_q  [DEPTH], rob_d  [DEPTH];
  logic [SQW-1:0]  tail_q [DEPTH], tail_d [DEPTH];
  logic [3:0]      use_q  [DEPTH], use_d  [DEPTH];
  logic [3:0]      fwd_q  [DEPTH], fwd_d  [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH], data_d [DEPTH];
  logic            exc_q  [DEPTH], exc_d  [DEPTH];

  logic            free_vld, sq_vld, ca_vld, done_vld;
  logic [IW-1:0]   free_idx, sq_idx, ca_idx, done_idx;
  logic [DEPTH-1:0] bc_hit;

  // Only word addresses take part in refill matching; byte offset bits are deliberately ignored.
  logic unused_bc_low;
  assign unused_bc_low = ^broadcast_addr[1:0];

  // Forwarded lanes (mask m) come from fwd, remaining lanes from src.
  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] fwd,
                                                 input logic [3:0] m,
                                                 input logic [XLEN-1:0] src);
    logic [XLEN-1:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m[b]}};
    return (fwd & mask) | (src & ~mask);
  endfunction

  // Priority pickers: descending loop so the lowest index wins.
  always_comb begin
    free_vld = 1'b0; free_idx = '0;
    sq_vld   = 1'b0; sq_idx   = '0;
    ca_vld   = 1'b0; ca_idx   = '0;
    done_vld = 1'b0; done_idx = '0;
    bc_hit   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (broadcast_en && (st_q[i] == S_CACHE || st_q[i] == S_MISS) &&
          addr_q[i][XLEN-1:2] == broadcast_addr[XLEN-1:2])
        bc_hit[i] = 1'b1;
      if (st_q[i] == S_FREE) begin free_vld = 1'b1; free_idx = IW'(i); end
      if (st_q[i] == S_SQ)   begin sq_vld   = 1'b1; sq_idx   = IW'(i); end
      if (st_q[i] == S_DONE) begin done_vld = 1'b1; done_idx = IW'(i); end
      // A CACHE entry caught by this cycle's refill does not need the cache port.
      if (st_q[i] == S_CACHE && !(broadcast_en &&
          addr_q[i][XLEN-1:2] == broadcast_addr[XLEN-1:2])) begin
        ca_vld = 1'b1; ca_idx = IW'(i);
      end
    end
  end

  assign fu_ready = free_vld;

  // Next-state for every entry.
  always_comb begin
    logic [XLEN-1:0] ea;
    logic [3:0]      ub;
    logic            mis;
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i] = st_q[i]; addr_d[i] = addr_q[i]; fn_d[i] = fn_q[i]; tag_d[i] = tag_q[i];
      rob_d[i] = rob_q[i]; tail_d[i] = tail_q[i]; use_d[i] = use_q[i]; fwd_d[i] = fwd_q[i];
      data_d[i] = data_q[i]; exc_d[i] = exc_q[i];
    end
    ea  = issue_base + issue_imm;
    ub  = 4'b1111;
    mis = 1'b0;
    case (issue_funct)
      3'b000, 3'b100: ub = 4'b0001 << ea[1:0];
      3'b001, 3'b101: begin ub = ea[1] ? 4'b1100 : 4'b0011; mis = ea[0]; end
      default:        begin ub = 4'b1111; mis = (ea[1:0] != 2'b00); end
    endcase

    if (sq_vld && !sq_stall) begin
      data_d[sq_idx] = sq_data;
      if ((use_q[sq_idx] & sq_usebytes) == use_q[sq_idx]) begin
        fwd_d[sq_idx] = use_q[sq_idx];
        st_d[sq_idx]  = S_DONE;
      end else begin
        fwd_d[sq_idx] = use_q[sq_idx] & sq_usebytes;
        st_d[sq_idx]  = S_CACHE;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (bc_hit[i]) begin
        data_d[i] = lane_merge(data_q[i], fwd_q[i], broadcast_data);
        st_d[i]   = S_DONE;
      end
    end

    if (ca_vld) begin
      if (cache_hit) begin
        data_d[ca_idx] = lane_merge(data_q[ca_idx], fwd_q[ca_idx], cache_data);
        st_d[ca_idx]   = S_DONE;
      end else begin
        st_d[ca_idx]   = S_MISS;
      end
    end

    if (done_vld && !complete_stall) st_d[done_idx] = S_FREE;

    if (issue_valid && free_vld && !squash) begin
      addr_d[free_idx] = ea;
      fn_d[free_idx]   = issue_funct;
      tag_d[free_idx]  = issue_dest_pr;
      rob_d[free_idx]  = issue_rob;
      tail_d[free_idx] = issue_sq_tail;
      use_d[free_idx]  = ub;
      fwd_d[free_idx]  = 4'b0000;
      data_d[free_idx] = '0;
      exc_d[free_idx]  = mis;
      st_d[free_idx]   = mis ? S_DONE : S_SQ;
    end

    if (squash) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = S_FREE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= S_FREE; addr_q[i] <= '0; fn_q[i] <= '0; tag_q[i] <= '0; rob_q[i] <= '0;
        tail_q[i] <= '0; use_q[i] <= '0; fwd_q[i] <= '0; data_q[i] <= '0; exc_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= st_d[i]; addr_q[i] <= addr_d[i]; fn_q[i] <= fn_d[i]; tag_q[i] <= tag_d[i];
        rob_q[i] <= rob_d[i]; tail_q[i] <= tail_d[i]; use_q[i] <= use_d[i]; fwd_q[i] <= fwd_d[i];
        data_q[i] <= data_d[i]; exc_q[i] <= exc_d[i];
      end
    end
  end

  // Request/response outputs are zero whenever their valid is low.
  always_comb begin
    logic [XLEN-1:0] sh;
    sq_lookup_valid  = sq_vld;
    sq_lookup_addr   = sq_vld ? {addr_q[sq_idx][XLEN-1:2], 2'b00} : '0;
    sq_lookup_tail   = sq_vld ? tail_q[sq_idx] : '0;
    cache_req        = ca_vld;
    cache_addr       = ca_vld ? {addr_q[ca_idx][XLEN-1:2], 2'b00} : '0;
    complete_valid   = done_vld;
    complete_dest_pr = done_vld ? tag_q[done_idx] : '0;
    complete_rob     = done_vld ? rob_q[done_idx] : '0;
    complete_exc     = done_vld && exc_q[done_idx];
    sh = data_q[done_idx] >> {addr_q[done_idx][1:0], 3'b000};
    case (fn_q[done_idx])
      3'b000:  complete_value = {{(XLEN-8){sh[7]}},   sh[7:0]};
      3'b001:  complete_value = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  complete_value = {{(XLEN-8){1'b0}},    sh[7:0]};
      3'b101:  complete_value = {{(XLEN-16){1'b0}},   sh[15:0]};
      default: complete_value = data_q[done_idx];
    endcase
    if (!done_vld || exc_q[done_idx]) complete_value = '0;
  end
endmodule

// File: tb/tb_fu_load_nb.sv
module tb_fu_load_nb;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_base = '0, issue_imm = '0;
  logic [2:0]  issue_funct = '0;
  logic [5:0]  issue_dest_pr = '0;
  logic [4:0]  issue_rob = '0;
  logic [2:0]  issue_sq_tail = '0;
  logic        fu_ready, squash = 1'b0;
  logic        sq_lookup_valid;
  logic [31:0] sq_lookup_addr;
  logic [2:0]  sq_lookup_tail;
  logic        sq_stall = 1'b0;
  logic [3:0]  sq_usebytes = '0;
  logic [31:0] sq_data = '0;
  logic        cache_req;
  logic [31:0] cache_addr;
  logic        cache_hit = 1'b0;
  logic [31:0] cache_data = '0;
  logic        broadcast_en = 1'b0;
  logic [31:0] broadcast_addr = '0, broadcast_data = '0;
  logic        complete_stall = 1'b0;
  logic        complete_valid;
  logic [5:0]  complete_dest_pr;
  logic [4:0]  complete_rob;
  logic [31:0] complete_value;
  logic        complete_exc;

  int n_assert = 0;
  int n_fail   = 0;

  fu_load_nb dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_base(issue_base), .issue_imm(issue_imm),
    .issue_funct(issue_funct), .issue_dest_pr(issue_dest_pr), .issue_rob(issue_rob),
    .issue_sq_tail(issue_sq_tail), .fu_ready(fu_ready), .squash(squash),
    .sq_lookup_valid(sq_lookup_valid), .sq_lookup_addr(sq_lookup_addr),
    .sq_lookup_tail(sq_lookup_tail), .sq_stall(sq_stall), .sq_usebytes(sq_usebytes),
    .sq_data(sq_data), .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_hit(cache_hit), .cache_data(cache_data), .broadcast_en(broadcast_en),
    .broadcast_addr(broadcast_addr), .broadcast_data(broadcast_data),
    .complete_stall(complete_stall), .complete_valid(complete_valid),
    .complete_dest_pr(complete_dest_pr), .complete_rob(complete_rob),
    .complete_value(complete_value), .complete_exc(complete_exc)
  );

  always #5 clock = ~clock;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a load for one cycle; on return we are in cycle N+1.
  task automatic issue(input logic [2:0] f, input logic [31:0] b, input logic [31:0] im,
                       input logic [5:0] d, input logic [4:0] r, input logic [2:0] t);
    issue_valid = 1'b1; issue_funct = f; issue_base = b; issue_imm = im;
    issue_dest_pr = d; issue_rob = r; issue_sq_tail = t;
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_fu_ready", fu_ready, 1);
    chk("rst_cvalid", complete_valid, 0);
    chk("rst_sqvalid", sq_lookup_valid, 0);
    chk("rst_creq", cache_req, 0);
    reset = 1'b0;
    step();

    // LB 0x1003, byte lane 3 forwarded -> sign-extended 0x80
    issue(3'b000, 32'h1000, 32'h3, 6'd7, 5'd3, 3'd5);
    chk("lb_sqvalid", sq_lookup_valid, 1);
    chk("lb_sqaddr", sq_lookup_addr, 32'h1000);
    chk("lb_sqtail", sq_lookup_tail, 5);
    chk("lb_early", complete_valid, 0);
    sq_usebytes = 4'b1000; sq_data = 32'h80123456;
    step();
    sq_usebytes = 4'b0000; sq_data = '0;
    chk("lb_valid", complete_valid, 1);
    chk("lb_value", complete_value, 32'hFFFFFF80);
    chk("lb_dest", complete_dest_pr, 7);
    chk("lb_rob", complete_rob, 3);
    step();
    chk("lb_freed", complete_valid, 0);

    // Same load as LBU -> zero-extended
    issue(3'b100, 32'h1000, 32'h3, 6'd8, 5'd4, 3'd5);
    sq_usebytes = 4'b1000; sq_data = 32'h80123456;
    step();
    sq_usebytes = 4'b0000; sq_data = '0;
    chk("lbu_value", complete_value, 32'h00000080);
    step();

    // LW with partial forward (low half) merged with a cache hit
    issue(3'b010, 32'h2000, 32'h0, 6'd9, 5'd5, 3'd1);
    sq_usebytes = 4'b0011; sq_data = 32'h0000BEEF;
    step();
    sq_usebytes = 4'b0000; sq_data = '0;
    chk("lw_creq", cache_req, 1);
    chk("lw_caddr", cache_addr, 32'h2000);
    chk("lw_early", complete_valid, 0);
    cache_hit = 1'b1; cache_data = 32'h12345678;
    step();
    cache_hit = 1'b0; cache_data = '0;
    chk("lw_valid", complete_valid, 1);
    chk("lw_merge", complete_value, 32'h1234BEEF);
    step();

    // Four misses fill the buffer; refill of the third word completes it first
    issue(3'b010, 32'h4000, 32'h0, 6'd10, 5'd10, 3'd0);
    issue(3'b010, 32'h4000, 32'h4, 6'd11, 5'd11, 3'd0);
    issue(3'b010, 32'h4000, 32'h8, 6'd12, 5'd12, 3'd0);
    issue(3'b010, 32'h4000, 32'hC, 6'd13, 5'd13, 3'd0);
    chk("full_fu_ready", fu_ready, 0);
    step(); step();
    chk("miss_sqidle", sq_lookup_valid, 0);
    chk("miss_cidle", cache_req, 0);
    chk("miss_novalid", complete_valid, 0);
    broadcast_en = 1'b1; broadcast_addr = 32'h4008; broadcast_data = 32'hCAFEF00D;
    step();
    broadcast_en = 1'b0; broadcast_addr = '0; broadcast_data = '0;
    chk("bc_valid", complete_valid, 1);
    chk("bc_rob", complete_rob, 12);
    chk("bc_value", complete_value, 32'hCAFEF00D);
    chk("bc_still_full", fu_ready, 0);
    step();
    chk("bc_freed", fu_ready, 1);
    chk("bc_done", complete_valid, 0);

    // Reset with three entries parked in MISS
    reset = 1'b1;
    step();
    chk("rst2_fu_ready", fu_ready, 1);
    chk("rst2_cvalid", complete_valid, 0);
    chk("rst2_sqvalid", sq_lookup_valid, 0);
    chk("rst2_creq", cache_req, 0);
    reset = 1'b0;
    broadcast_en = 1'b1; broadcast_addr = 32'h4000; broadcast_data = 32'h11111111;
    step();
    broadcast_en = 1'b0;
    chk("rst2_no_bc", complete_valid, 0);

    // Misaligned LH completes at N+1, held under complete_stall
    issue(3'b001, 32'h3000, 32'h1, 6'd20, 5'd20, 3'd0);
    complete_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mis_valid", complete_valid, 1);
      chk("mis_exc", complete_exc, 1);
      chk("mis_value", complete_value, 0);
      chk("mis_dest", complete_dest_pr, 20);
      step();
    end
    complete_stall = 1'b0;
    chk("mis_release", complete_valid, 1);
    step();
    chk("mis_freed", complete_valid, 0);

    // sq_stall for 4 cycles then full forward: completion at N+6
    issue(3'b010, 32'h5000, 32'h0, 6'd21, 5'd21, 3'd2);
    sq_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_sqvalid", sq_lookup_valid, 1);
      step();
    end
    sq_stall = 1'b0; sq_usebytes = 4'b1111; sq_data = 32'hA5A5A5A5;
    chk("stall_early", complete_valid, 0);
    step();
    sq_usebytes = 4'b0000; sq_data = '0;
    chk("stall_valid", complete_valid, 1);
    chk("stall_value", complete_value, 32'hA5A5A5A5);
    step();

    // Squash during an SQ stall; a concurrent issue is ignored
    issue(3'b010, 32'h6000, 32'h0, 6'd22, 5'd22, 3'd3);
    sq_stall = 1'b1;
    step();
    squash = 1'b1;
    issue(3'b010, 32'h7000, 32'h0, 6'd23, 5'd23, 3'd3);
    squash = 1'b0; sq_stall = 1'b0;
    chk("sqsh_fu_ready", fu_ready, 1);
    chk("sqsh_sqvalid", sq_lookup_valid, 0);
    chk("sqsh_cvalid", complete_valid, 0);
    broadcast_en = 1'b1; broadcast_addr = 32'h6000; broadcast_data = 32'h22222222;
    sq_usebytes = 4'b1111;
    step();
    broadcast_en = 1'b0; sq_usebytes = 4'b0000;
    step();
    chk("sqsh_no_cmpl", complete_valid, 0);
    chk("sqsh_no_creq", cache_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fu_load_nb.md
Name: fu_load_nb

Overview:
Non-blocking, multi-entry load functional unit for the R10K out-of-order core. It sits between the issue stage and the complete stage, alongside the SQ and the D-cache. It holds up to DEPTH loads in flight and performs store-to-load forwarding through a shared SQ lookup port and reads through a shared cache port. Loads that miss park until a matching cache refill broadcast arrives, and loads may complete out of order.

Parameters:
DEPTH, 4, number of load-buffer entries (power of 2, ≥2)
XLEN, 32, data and address width
PRW, 6, physical register tag width
ROBW, 5, ROB index width
SQW, 3, SQ tail-pointer width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; all entries forced FREE
issue_valid  in  1  load offered by issue stage
issue_base  in  XLEN  rs1 value
issue_imm  in  XLEN  sign-extended I-immediate
issue_funct  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101
issue_dest_pr  in  PRW  destination tag
issue_rob  in  ROBW  ROB index
issue_sq_tail  in  SQW  SQ tail at dispatch
fu_ready  out  1  at least one FREE entry
squash  in  1  flush all in-flight loads
sq_lookup_valid  out  1  lookup request this cycle
sq_lookup_addr  out  XLEN  word-aligned address
sq_lookup_tail  out  SQW  tail of the requesting entry
sq_stall  in  1  older store address unknown; retry
sq_usebytes  in  4  bytes the SQ can forward
sq_data  in  XLEN  forwarded word, lane-aligned
cache_req  out  1  cache read request
cache_addr  out  XLEN  word-aligned address
cache_hit  in  1  same-cycle hit
cache_data  in  XLEN  hit data
broadcast_en  in  1  refill broadcast valid
broadcast_addr  in  XLEN  word address of refill
broadcast_data  in  XLEN  refill word
complete_stall  in  1  CDB busy
complete_valid  out  1  result presented
complete_dest_pr  out  PRW
complete_rob  out  ROBW
complete_value  out  XLEN  extended load result
complete_exc  out  1  misaligned-access flag

Behaviour:
- Per-entry states: FREE, SQ, CACHE, MISS, DONE. Each entry stores addr, funct, tag, rob, tail, usebytes, fwd_bytes, and data.
- Reset (async) sets all entries to FREE. After reset, fu_ready=1 and all other outputs are 0.
- fu_ready = any FREE entry, computed from current state only. A completion in the same cycle does not create space (no bypass).
- Issue: when issue_valid && fu_ready && !squash, the lowest-index FREE entry is loaded with addr = base + imm (mod 2^XLEN).
  - usebytes: byte loads give one-hot addr[1:0]; halfword loads give 0011 or 1100; LW gives 1111.
  - A misaligned access (LH/LHU with addr[0]=1, LW with addr[1:0]≠0) enters DONE directly with exc=1 and value 0.
  - Otherwise the entry enters SQ.
- SQ arbitration: the lowest-index SQ entry drives the lookup combinationally.
  - sq_stall: the entry stays in SQ.
  - (usebytes & sq_usebytes) == usebytes: latch the forwarded word and go to DONE.
  - Otherwise: latch fwd_bytes = usebytes & sq_usebytes and the forwarded data, then go to CACHE.
- Cache arbitration: the lowest-index CACHE entry asserts cache_req.
  - Hit: merge lanes (forwarded lanes override cache lanes) and go to DONE.
  - Miss: go to MISS.
- Broadcast: every entry in CACHE or MISS whose addr[XLEN-1:2] equals broadcast_addr[XLEN-1:2] merges broadcast_data (forwarded lanes override) and goes to DONE in the same cycle. A CACHE entry matched by a broadcast does not issue cache_req.
- Completion: the lowest-index DONE entry drives the complete_* outputs combinationally.
  - complete_value is formed by lane select plus sign or zero extension per funct.
  - On complete_valid && !complete_stall the entry becomes FREE next cycle.
  - While complete_stall is high, the presented outputs stay stable.
- Latency from the issue cycle N:
  - Full forward: complete_valid at N+2.
  - Cache hit: complete_valid at N+3.
  - Misaligned: complete_valid at N+1.
- Squash: synchronous. All entries become FREE next cycle and issue that cycle is ignored. Later broadcasts for squashed addresses have no effect.
- A newly allocated entry is not eligible for arbitration until the cycle after allocation.

Test Plan:
- Reset mid-operation (3 entries in MISS) → next cycle fu_ready=1, complete_valid=0, sq_lookup_valid=0, cache_req=0.
- LB base=0x1000 imm=3, SQ returns usebytes=1000 data=0x80xxxxxx → complete_value=0xFFFFFF80 at N+2; the same load as LBU → 0x00000080.
- LW base=0x2000, sq_usebytes=0011 data=0x0000BEEF, cache hit 0x12345678 → complete_value=0x1234BEEF at N+3.
- Four LW loads to distinct words, all misses, buffer full → fu_ready=0. Broadcast for the third entry's word (0xCAFEF00D) → that entry completes first with 0xCAFEF00D.
- LH addr=0x3001 → complete_exc=1 and value 0 at N+1. With complete_stall held 3 cycles, the outputs remain stable and the entry stays allocated.
- sq_stall held 4 cycles then released with full forward → completion 4 cycles later than nominal. A squash asserted during the stall → no completion, and fu_ready=1 next cycle.
